// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port RAM arbiter: VGA fixed priority, CPU/GPU round-robin, one ack per transaction
// Optional CPU low-address write protection: MEM_ARB_WRITE_PROTECT_EN
module mem_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8,
  parameter logic [ADDR_W-1:0] PROTECT_LIMIT = 12'h200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_read,
  input  logic [ADDR_W-1:0] cpu_read_addr,
  output logic [DATA_W-1:0] cpu_read_data,
  output logic              cpu_read_ack,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_write_addr,
  input  logic [DATA_W-1:0] cpu_write_data,
  output logic              cpu_write_ack,
  input  logic              gpu_read,
  input  logic [ADDR_W-1:0] gpu_read_addr,
  output logic [DATA_W-1:0] gpu_read_data,
  output logic              gpu_read_ack,
  input  logic              gpu_write,
  input  logic [ADDR_W-1:0] gpu_write_addr,
  input  logic [DATA_W-1:0] gpu_write_data,
  output logic              gpu_write_ack,
  input  logic              vga_read,
  input  logic [ADDR_W-1:0] vga_read_addr,
  output logic [DATA_W-1:0] vga_read_data,
  output logic              vga_read_ack,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              protect_violation
);

`ifdef MEM_ARB_WRITE_PROTECT_EN
  localparam bit PROTECT_EN = 1'b1;
`else
  localparam bit PROTECT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ACCESS, RESP, DONE} state_t;
  typedef enum logic [1:0] {GNT_CPU, GNT_GPU, GNT_VGA} gnt_t;

  state_t state;
  gnt_t   gnt;
  logic   gnt_we;
  logic   rr_gpu_next;
  logic   prot_q;

  logic cpu_pend;
  logic gpu_pend;
  logic pick_gpu;
  logic cpu_wr_blocked;

  assign cpu_pend       = cpu_read | cpu_write;
  assign gpu_pend       = gpu_read | gpu_write;
  assign pick_gpu       = gpu_pend & (~cpu_pend | rr_gpu_next);
  // Blocked CPU writes still run the full handshake, only the RAM strobe is suppressed.
  assign cpu_wr_blocked = PROTECT_EN & cpu_write & (cpu_write_addr < PROTECT_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      gnt               <= GNT_CPU;
      gnt_we            <= 1'b0;
      rr_gpu_next       <= 1'b0;
      prot_q            <= 1'b0;
      cpu_read_ack      <= 1'b0;
      cpu_write_ack     <= 1'b0;
      gpu_read_ack      <= 1'b0;
      gpu_write_ack     <= 1'b0;
      vga_read_ack      <= 1'b0;
      cpu_read_data     <= '0;
      gpu_read_data     <= '0;
      vga_read_data     <= '0;
      ram_en            <= 1'b0;
      ram_we            <= 1'b0;
      ram_addr          <= '0;
      ram_wdata         <= '0;
      protect_violation <= 1'b0;
    end else begin
      cpu_read_ack  <= 1'b0;
      cpu_write_ack <= 1'b0;
      gpu_read_ack  <= 1'b0;
      gpu_write_ack <= 1'b0;
      vga_read_ack  <= 1'b0;
      case (state)
        IDLE: begin
          if (vga_read) begin
            gnt      <= GNT_VGA;
            gnt_we   <= 1'b0;
            prot_q   <= 1'b0;
            ram_en   <= 1'b1;
            ram_we   <= 1'b0;
            ram_addr <= vga_read_addr;
            state    <= ACCESS;
          end else if (pick_gpu) begin
            gnt         <= GNT_GPU;
            rr_gpu_next <= 1'b0;
            gnt_we      <= gpu_write;
            prot_q      <= 1'b0;
            ram_en      <= 1'b1;
            ram_we      <= gpu_write;
            ram_addr    <= gpu_write ? gpu_write_addr : gpu_read_addr;
            ram_wdata   <= gpu_write_data;
            state       <= ACCESS;
          end else if (cpu_pend) begin
            gnt         <= GNT_CPU;
            rr_gpu_next <= 1'b1;
            gnt_we      <= cpu_write;
            prot_q      <= cpu_wr_blocked;
            ram_en      <= ~cpu_wr_blocked;
            ram_we      <= cpu_write & ~cpu_wr_blocked;
            ram_addr    <= cpu_write ? cpu_write_addr : cpu_read_addr;
            ram_wdata   <= cpu_write_data;
            state       <= ACCESS;
          end
        end
        ACCESS: begin
          ram_en <= 1'b0;
          ram_we <= 1'b0;
          if (gnt_we) begin
            case (gnt)
              GNT_CPU: cpu_write_ack <= 1'b1;
              GNT_GPU: gpu_write_ack <= 1'b1;
              default: ;
            endcase
            if (prot_q) protect_violation <= 1'b1;
            state <= DONE;
          end else begin
            state <= RESP;
          end
        end
        RESP: begin
          case (gnt)
            GNT_CPU: begin
              cpu_read_data <= ram_rdata;
              cpu_read_ack  <= 1'b1;
            end
            GNT_GPU: begin
              gpu_read_data <= ram_rdata;
              gpu_read_ack  <= 1'b1;
            end
            default: begin
              vga_read_data <= ram_rdata;
              vga_read_ack  <= 1'b1;
            end
          endcase
          state <= DONE;
        end
        DONE: begin
          // Ack is visible this cycle; no grant so the requester can withdraw.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port synchronous RAM (one access per cycle, 1-cycle read latency) between three requesters: CPU (read/write), GPU (read/write) and VGA scan-out (read only).
- Sits between the CPU, GPU and VGA request buses and the raw RAM array.
- VGA has fixed top priority. CPU and GPU are served round-robin.
- Every transaction completes with a one-cycle ack pulse.

Parameters:
- ADDR_W, 12, address width of all request ports and RAM.
- DATA_W, 8, data width.
- PROTECT_LIMIT, 12'h200, first writable address when MEM_ARB_WRITE_PROTECT_EN is defined.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cpu_read  in  1  CPU read request, level, held until cpu_read_ack
- cpu_read_addr  in  ADDR_W  CPU read address
- cpu_read_data  out  DATA_W  CPU read data, valid while cpu_read_ack=1
- cpu_read_ack  out  1  one-cycle completion pulse
- cpu_write  in  1  CPU write request, level, held until cpu_write_ack
- cpu_write_addr  in  ADDR_W  CPU write address
- cpu_write_data  in  DATA_W  CPU write data
- cpu_write_ack  out  1  one-cycle completion pulse
- gpu_read, gpu_read_addr, gpu_read_data, gpu_read_ack  in/in/out/out  1/ADDR_W/DATA_W/1  same as CPU read channel
- gpu_write, gpu_write_addr, gpu_write_data, gpu_write_ack  in/in/in/out  1/ADDR_W/DATA_W/1  same as CPU write channel
- vga_read, vga_read_addr, vga_read_data, vga_read_ack  in/in/out/out  1/ADDR_W/DATA_W/1  VGA read channel
- ram_en  out  1  RAM access strobe
- ram_we  out  1  RAM write enable, qualified by ram_en
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, valid the cycle after ram_en with ram_we=0
- protect_violation  out  1  sticky flag; constant 0 when the optional feature is off

Behaviour:
- Clock/reset: single clock domain, clk. rst is synchronous, active-high.
- Reset values:
  - state=IDLE, all *_ack=0, all *_read_data=0.
  - ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0.
  - rr_gpu_next=0 (CPU favoured first), protect_violation=0.
- FSM states: IDLE, ACCESS, RESP, DONE.
- IDLE: evaluate requests sampled at the edge. Priority:
  1. vga_read.
  2. The round-robin winner between CPU and GPU. A requester with any request pending is a candidate. When both are candidates, rr_gpu_next selects.
  3. Within the winning requester, write beats read.
- On grant, register grant id, ram_en=1, ram_we, ram_addr, ram_wdata, then go to ACCESS.
- No request pending: stay in IDLE with ram_en=0.
- ACCESS: RAM samples at the edge ending this cycle. Then ram_en=0 and ram_we=0.
  - Write: go to DONE.
  - Read: go to RESP.
- RESP: ram_rdata is valid. Latch it into the granted requester's *_read_data and go to DONE.
- DONE: assert the granted requester's ack for exactly this cycle. No grant in this cycle, so the requester can drop its request. Go to IDLE.
- Latency, counting edges from IDLE sampling a request:
  - Write: ack high 2 cycles after the sampling edge.
  - Read: ack high 3 cycles after.
  - Maximum throughput: one read per 4 cycles, one write per 3 cycles.
- Round-robin: on a CPU grant, set rr_gpu_next=1. On a GPU grant, set rr_gpu_next=0. VGA grants leave the pointer unchanged.
- Only one ack is high in any cycle.
- *_read_data holds its value after ack until that channel's next read completes.
- Request and address inputs are sampled only in IDLE. Changes during ACCESS/RESP/DONE are ignored.
- Dropping a request before its ack is illegal. The arbiter completes the access anyway.
- Reset mid-transaction: abort immediately, return to IDLE, no ack issued. An in-flight write may or may not have reached the RAM. A requester still asserting request after reset is re-served.
- Addresses pass through unmodified. No wrap or range logic except under the optional feature.

Optional Feature:
- MEM_ARB_WRITE_PROTECT_EN defined:
  - A CPU write with cpu_write_addr < PROTECT_LIMIT (font/interpreter area) is granted normally, but ram_en stays 0 in ACCESS.
  - cpu_write_ack is still pulsed in DONE, and protect_violation is set.
  - protect_violation is sticky and is cleared only by rst.
  - GPU writes and all reads are unaffected.
- Undefined: no address check; protect_violation tied to 0.

Test Plan:
- CPU read 0x200 (RAM holds 0xA5) → ram_en/we=1/0 one cycle, cpu_read_ack high 3 cycles after the request edge with cpu_read_data=0xA5; no other ack.
- GPU write 0x345←0x3C, then GPU read 0x345 → write ack at +2; read returns 0x3C.
- CPU and GPU reads asserted simultaneously and held continuously after each ack → grants alternate CPU, GPU, CPU, GPU; each ack 4 cycles apart.
- VGA, CPU and GPU all requesting → VGA served first every time it is pending; CPU/GPU pointer unchanged by VGA grants.
- rst asserted during RESP of a CPU read → all acks stay 0, state IDLE next cycle; held cpu_read is re-served and acked 3 cycles after the first non-reset edge.
- MEM_ARB_WRITE_PROTECT_EN: CPU write 0x050←0xFF → ack pulsed, ram_en never high, protect_violation=1 and stays 1. Write to 0x200 → ram_en=1, RAM updated.
